// File: rtl/icnd2110_rx_pkg.sv
// Shared constants, state encodings and small helpers for the ICND2110 stream receiver.
// The field sizes match the icnd2110_out transmitter.
package icnd2110_rx_pkg;

    localparam int unsigned START_ONES  = 128;
    localparam int unsigned BLANK_BITS  = 16;
    localparam int unsigned WORD_BITS   = 16;
    localparam int unsigned GROUP_WORDS = 6;
    localparam int unsigned CHIP_WORDS  = 12;
    localparam int unsigned END_ONES    = 145;
    localparam int unsigned GROUP_BITS  = GROUP_WORDS * WORD_BITS;

    localparam logic [2:0] ST_HUNT   = 3'd0;
    localparam logic [2:0] ST_BLANK0 = 3'd1;
    localparam logic [2:0] ST_REG    = 3'd2;
    localparam logic [2:0] ST_BLANK1 = 3'd3;
    localparam logic [2:0] ST_GROUP  = 3'd4;
    localparam logic [2:0] ST_GBLANK = 3'd5;
    localparam logic [2:0] ST_END    = 3'd6;

    localparam logic HALF_A = 1'b0;
    localparam logic HALF_B = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Offset of group word k inside its chip: the transmitter sends each half last-word-first.
    function automatic logic [3:0] commit_offset(input logic half, input logic [2:0] k);
        return ((half == HALF_B) ? 4'd6 : 4'd0) + (4'd5 - {1'b0, k});
    endfunction

endpackage

// File: rtl/icnd2110_rx_sync.sv
// Brings sck/sdi into the clk domain and emits one bit per sck rising edge.
// Optional 3-sample majority filter: ICND2110_RX_GLITCH_FILTER_EN.
module icnd2110_rx_sync
    import icnd2110_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic sdi,
    output logic bit_valid,
    output logic bit_data
);

    logic [1:0] sck_sync;
    logic [1:0] sdi_sync;
    logic       sck_clean;
    logic       sdi_clean;
    logic       sck_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            sdi_sync <= '0;
        end else begin
            sck_sync <= {sck_sync[0], sck};
            sdi_sync <= {sdi_sync[0], sdi};
        end
    end

`ifdef ICND2110_RX_GLITCH_FILTER_EN
    logic [1:0] sck_hist;
    logic [1:0] sdi_hist;

    // Both lines go through identical delay so sdi stays aligned with the filtered sck edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_hist  <= '0;
            sdi_hist  <= '0;
            sck_clean <= 1'b0;
            sdi_clean <= 1'b0;
        end else begin
            sck_hist  <= {sck_hist[0], sck_sync[1]};
            sdi_hist  <= {sdi_hist[0], sdi_sync[1]};
            sck_clean <= majority3(sck_sync[1], sck_hist[0], sck_hist[1]);
            sdi_clean <= majority3(sdi_sync[1], sdi_hist[0], sdi_hist[1]);
        end
    end
`else
    always_comb begin
        sck_clean = sck_sync[1];
        sdi_clean = sdi_sync[1];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_prev  <= 1'b0;
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
        end else begin
            sck_prev  <= sck_clean;
            bit_valid <= sck_clean & ~sck_prev;
            bit_data  <= sdi_clean;
        end
    end

endmodule

// File: rtl/icnd2110_rx.sv
// ICND2110 stream receiver: locks on the start run, captures the config register and
// pixel words, and writes each word at its linear address. Build option: ICND2110_RX_GLITCH_FILTER_EN.
module icnd2110_rx
    import icnd2110_rx_pkg::*;
#(
    parameter int unsigned ADDRESS_BUS_WIDTH = 16,
    parameter int unsigned START_ONES_MIN    = START_ONES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sck,
    input  logic                         sdi,
    input  logic [15:0]                  start_address,
    output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
    output logic [15:0]                  write_data,
    output logic                         write_strobe,
    output logic [15:0]                  reg_value,
    output logic [15:0]                  word_count,
    output logic                         frame_done,
    output logic                         error
);

    localparam int unsigned AW = ADDRESS_BUS_WIDTH;
    localparam int unsigned RW = $clog2(START_ONES_MIN + 1);
    localparam logic [RW-1:0] RUN_MIN = RW'(START_ONES_MIN);

    logic          bit_valid;
    logic          bit_data;

    logic [2:0]    state;
    logic [RW-1:0] run;
    logic [6:0]    bit_cnt;
    logic [14:0]   shreg;
    logic          all_ones;
    logic          half;
    logic [AW-1:0] grp_base;
    logic [15:0]   frame_words;
    logic          busy;
    logic [2:0]    commit_k;
    logic          pend_v;
    logic          pend_d;

    logic          cur_v;
    logic          cur_d;
    logic          take;

    logic [15:0]   word_buf [GROUP_WORDS];
    logic          buf_we;
    logic [2:0]    buf_idx;
    logic [15:0]   buf_word;

    icnd2110_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .sdi       (sdi),
        .bit_valid (bit_valid),
        .bit_data  (bit_data)
    );

    // A bit arriving mid-commit waits in pend_* and is decoded once the commit finishes.
    always_comb begin
        cur_v = pend_v | bit_valid;
        cur_d = pend_v ? pend_d : bit_data;
        take  = cur_v & ~busy;
    end

    always_comb begin
        buf_we   = take && (state == ST_GROUP) && (bit_cnt < 7'(GROUP_BITS))
                   && (bit_cnt[3:0] == 4'hF);
        buf_idx  = bit_cnt[6:4];
        buf_word = {shreg, cur_d};
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            word_buf[buf_idx] <= buf_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_HUNT;
            run           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            all_ones      <= 1'b0;
            half          <= HALF_A;
            grp_base      <= '0;
            frame_words   <= '0;
            busy          <= 1'b0;
            commit_k      <= '0;
            pend_v        <= 1'b0;
            pend_d        <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            write_strobe  <= 1'b0;
            reg_value     <= '0;
            word_count    <= '0;
            frame_done    <= 1'b0;
            error         <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            frame_done   <= 1'b0;

            if (bit_valid && (busy || pend_v)) begin
                pend_v <= 1'b1;
                pend_d <= bit_data;
            end else if (take) begin
                pend_v <= 1'b0;
            end

            if (busy) begin
                write_strobe  <= 1'b1;
                write_address <= AW'(start_address) + grp_base + AW'(commit_offset(half, commit_k));
                write_data    <= word_buf[commit_k];
                frame_words   <= frame_words + 16'd1;
                if (commit_k == 3'(GROUP_WORDS - 1)) begin
                    busy     <= 1'b0;
                    commit_k <= '0;
                    half     <= ~half;
                    if (half == HALF_B) begin
                        grp_base <= grp_base + AW'(CHIP_WORDS);
                    end
                end else begin
                    commit_k <= commit_k + 3'd1;
                end
            end

            if (take) begin
                case (state)
                    ST_HUNT: begin
                        if (cur_d) begin
                            if (run != RUN_MIN) begin
                                run <= run + RW'(1);
                            end
                        end else begin
                            if (run == RUN_MIN) begin
                                state       <= ST_BLANK0;
                                bit_cnt     <= 7'd1;
                                half        <= HALF_A;
                                grp_base    <= '0;
                                frame_words <= '0;
                            end
                            run <= '0;
                        end
                    end

                    ST_BLANK0, ST_BLANK1, ST_GBLANK: begin
                        if (cur_d) begin
                            // The offending 1 already counts toward the next start run.
                            error   <= 1'b1;
                            state   <= ST_HUNT;
                            run     <= RW'(1);
                            bit_cnt <= '0;
                        end else if (bit_cnt == 7'(BLANK_BITS - 1)) begin
                            bit_cnt  <= '0;
                            all_ones <= 1'b1;
                            if (state == ST_BLANK0) begin
                                state <= ST_REG;
                            end else begin
                                state <= ST_GROUP;
                                if (state == ST_BLANK1) begin
                                    half <= HALF_A;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                    end

                    ST_REG: begin
                        shreg <= {shreg[13:0], cur_d};
                        if (bit_cnt == 7'(WORD_BITS - 1)) begin
                            reg_value <= {shreg, cur_d};
                            state     <= ST_BLANK1;
                            bit_cnt   <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                    end

                    ST_GROUP: begin
                        if (bit_cnt == 7'(GROUP_BITS)) begin
                            if (!cur_d) begin
                                busy     <= 1'b1;
                                commit_k <= '0;
                                state    <= ST_GBLANK;
                                bit_cnt  <= 7'd1;
                            end else if ((half == HALF_A) && all_ones) begin
                                frame_done <= 1'b1;
                                word_count <= frame_words;
                                state      <= ST_END;
                                bit_cnt    <= '0;
                            end else begin
                                error   <= 1'b1;
                                state   <= ST_HUNT;
                                run     <= RW'(1);
                                bit_cnt <= '0;
                            end
                        end else begin
                            shreg    <= {shreg[13:0], cur_d};
                            all_ones <= all_ones & cur_d;
                            bit_cnt  <= bit_cnt + 7'd1;
                        end
                    end

                    ST_END: begin
                        if (!cur_d) begin
                            state <= ST_HUNT;
                            run   <= '0;
                        end
                    end

                    default: begin
                        state <= ST_HUNT;
                        run   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_icnd2110_rx.sv
// Directed bench for icnd2110_rx: a transmitter model builds bit streams and a memory
// scoreboard holds the image each frame must leave behind.
module tb_icnd2110_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        sdi;
    logic [15:0] start_address;
    logic [15:0] write_address;
    logic [15:0] write_data;
    logic        write_strobe;
    logic [15:0] reg_value;
    logic [15:0] word_count;
    logic        frame_done;
    logic        error;

    icnd2110_rx #(
        .ADDRESS_BUS_WIDTH (16),
        .START_ONES_MIN    (128)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sck           (sck),
        .sdi           (sdi),
        .start_address (start_address),
        .write_address (write_address),
        .write_data    (write_data),
        .write_strobe  (write_strobe),
        .reg_value     (reg_value),
        .word_count    (word_count),
        .frame_done    (frame_done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_mem [int];
    logic [15:0] exp_wc   = '0;
    logic [15:0] exp_reg  = 16'h0017;
    int          writes_seen = 0;
    int          done_seen   = 0;
    bit          sb_off      = 1'b0;
    int          glitch_bad  = 0;
    bit          capture_first = 1'b0;
    logic [15:0] first_addr = '0, first_data = '0, last_addr = '0, last_data = '0;
    bit          stream [$];
    logic [15:0] words [$];
    int          w0, d0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every committed word must land on an address still owed by the current frame.
    always @(posedge clk) begin
        #1;
        if (write_strobe) begin
            writes_seen++;
            if (capture_first) begin
                first_addr    = write_address;
                first_data    = write_data;
                capture_first = 1'b0;
            end
            last_addr = write_address;
            last_data = write_data;
            if (sb_off) begin
                if (exp_mem.exists(int'(write_address)) && exp_mem[int'(write_address)] === write_data)
                    exp_mem.delete(int'(write_address));
                else
                    glitch_bad++;
            end else if (exp_mem.exists(int'(write_address))) begin
                check($sformatf("write_data@%04h", write_address), write_data, exp_mem[int'(write_address)]);
                exp_mem.delete(int'(write_address));
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%04h data 0x%04h, no write owed there",
                         write_address, write_data);
            end
        end
        if (frame_done) begin
            done_seen++;
            if (!sb_off) begin
                check("word_count_at_end", word_count, exp_wc);
                check("reg_value_at_end", reg_value, exp_reg);
            end
        end
    end

    task automatic push_n(input bit b, input int n);
        repeat (n) stream.push_back(b);
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) stream.push_back(w[i]);
    endtask

    // Transmitter view: per chip, each 6-word half goes out last word first.
    task automatic build_frame(input int start_ones, input bit with_end);
        stream.delete();
        push_n(1'b1, start_ones);
        push_n(1'b0, 16);
        push_word(16'h0017);
        push_n(1'b0, 16);
        for (int c = 0; c < words.size() / 12; c++)
            for (int h = 0; h < 2; h++) begin
                for (int k = 0; k < 6; k++) push_word(words[c*12 + h*6 + 5 - k]);
                push_n(1'b0, 16);
            end
        if (with_end) push_n(1'b1, 145);
        push_n(1'b0, 2);
    endtask

    task automatic load_words(input logic [15:0] base_data, input int n, input bit ones);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(ones ? 16'hFFFF : base_data + 16'(i));
    endtask

    task automatic expect_writes(input logic [15:0] base_addr, input int n);
        exp_mem.delete();
        for (int i = 0; i < n; i++) exp_mem[int'(base_addr) + i] = words[i];
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        sck = 1'b0;
        sdi = b;
        if (glitch) begin
            repeat (2) @(negedge clk);
            sck = 1'b1;
            @(negedge clk);
            sck = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
        sck = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_stream(input int from, input int to, input int glitch_at);
        for (int i = from; i < to; i++) send_bit(stream[i], i == glitch_at);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write_address"}, write_address, 0);
        check({tag, "_write_data"}, write_data, 0);
        check({tag, "_write_strobe"}, write_strobe, 0);
        check({tag, "_reg_value"}, reg_value, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic check_clean_frame(input string tag, input int n);
        check({tag, "_writes"}, writes_seen - w0, n);
        check({tag, "_owed_left"}, exp_mem.num(), 0);
        check({tag, "_frame_done"}, done_seen - d0, 1);
        check({tag, "_word_count"}, word_count, n);
        check({tag, "_reg_value"}, reg_value, 16'h0017);
    endtask

    initial begin
        rst = 1'b1;
        sck = 1'b0;
        sdi = 1'b0;
        start_address = '0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 24 words, addresses and data line up linearly
        start_address = 16'h0100;
        load_words(16'h1000, 24, 1'b0);
        expect_writes(16'h0100, 24);
        exp_wc = 16'd24;
        build_frame(128, 1'b1);
        w0 = writes_seen; d0 = done_seen; capture_first = 1'b1;
        send_stream(0, stream.size(), -1);
        repeat (20) @(negedge clk);
        check_clean_frame("t1", 24);
        check("t1_first_addr", first_addr, 16'h0105);
        check("t1_first_data", first_data, 16'h1005);
        check("t1_last_addr", last_addr, 16'h0112);
        check("t1_last_data", last_data, 16'h1012);
        check("t1_error", error, 0);

        // 2: all-ones words are data, not an end marker
        start_address = 16'h0200;
        load_words(16'h0000, 12, 1'b1);
        expect_writes(16'h0200, 12);
        exp_wc = 16'd12;
        build_frame(128, 1'b1);
        w0 = writes_seen; d0 = done_seen;
        send_stream(0, stream.size(), -1);
        repeat (20) @(negedge clk);
        check_clean_frame("t2", 12);
        check("t2_error", error, 0);

        // 3: a 1 at bit 5 of the second group blank; first chip already committed
        start_address = 16'h0300;
        load_words(16'h3000, 24, 1'b0);
        expect_writes(16'h0300, 12);
        build_frame(128, 1'b1);
        stream[128 + 48 + 96 + 16 + 96 + 5] = 1'b1;
        w0 = writes_seen; d0 = done_seen;
        send_stream(0, stream.size(), -1);
        repeat (20) @(negedge clk);
        check("t3_writes", writes_seen - w0, 12);
        check("t3_owed_left", exp_mem.num(), 0);
        check("t3_frame_done", done_seen - d0, 0);
        check("t3_error", error, 1);

        start_address = 16'h0400;
        load_words(16'h4000, 12, 1'b0);
        expect_writes(16'h0400, 12);
        exp_wc = 16'd12;
        build_frame(130, 1'b1);
        w0 = writes_seen; d0 = done_seen;
        send_stream(0, stream.size(), -1);
        repeat (20) @(negedge clk);
        check_clean_frame("t3b", 12);
        check("t3b_error_sticky", error, 1);

        // 4: a 127-one run must not lock; 128 must
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("t4_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_address = 16'h0500;
        load_words(16'h5000, 12, 1'b0);
        exp_mem.delete();
        build_frame(127, 1'b0);
        w0 = writes_seen; d0 = done_seen;
        send_stream(0, stream.size(), -1);
        repeat (20) @(negedge clk);
        check("t4a_writes", writes_seen - w0, 0);
        check("t4a_frame_done", done_seen - d0, 0);
        check("t4a_error", error, 0);

        start_address = 16'h0600;
        load_words(16'h6000, 12, 1'b0);
        expect_writes(16'h0600, 12);
        exp_wc = 16'd12;
        build_frame(128, 1'b1);
        w0 = writes_seen; d0 = done_seen;
        send_stream(0, stream.size(), -1);
        repeat (20) @(negedge clk);
        check_clean_frame("t4b", 12);
        check("t4b_error", error, 0);

        // 5: reset while word 3 of the first group is arriving
        start_address = 16'h0700;
        load_words(16'h7000, 24, 1'b0);
        exp_mem.delete();
        build_frame(128, 1'b1);
        w0 = writes_seen; d0 = done_seen;
        send_stream(0, 128 + 48 + 3*16 + 8, -1);
        rst = 1'b1;
        sck = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("t5_reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_writes", writes_seen - w0, 0);
        check("t5_frame_done", done_seen - d0, 0);

        start_address = 16'h0800;
        load_words(16'h8000, 12, 1'b0);
        expect_writes(16'h0800, 12);
        exp_wc = 16'd12;
        build_frame(128, 1'b1);
        w0 = writes_seen; d0 = done_seen;
        send_stream(0, stream.size(), -1);
        repeat (20) @(negedge clk);
        check_clean_frame("t5b", 12);
        check("t5b_error", error, 0);

        // 6: one-clk sck pulse at the MSB of group word 2 (0x9003)
        start_address = 16'h0900;
        load_words(16'h9000, 12, 1'b0);
        expect_writes(16'h0900, 12);
        exp_wc = 16'd12;
        build_frame(128, 1'b1);
        w0 = writes_seen; d0 = done_seen;
`ifdef ICND2110_RX_GLITCH_FILTER_EN
        send_stream(0, stream.size(), 128 + 48 + 2*16);
        repeat (20) @(negedge clk);
        check_clean_frame("t6", 12);
        check("t6_error", error, 0);
`else
        sb_off = 1'b1;
        glitch_bad = 0;
        send_stream(0, stream.size(), 128 + 48 + 2*16);
        repeat (20) @(negedge clk);
        check("t6_glitch_corrupts",
              (error || glitch_bad != 0 || (writes_seen - w0) != 12 || exp_mem.num() != 0) ? 1 : 0, 1);
        sb_off = 1'b0;
        exp_mem.delete();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
